mux_4to1_sv: RTL and testbench
==============================

# mux_4to1_sv

Selects one of four 1-bit data inputs onto a single output using a 2-bit select. It provides both a combinational output and a registered copy of it. It is a generic datapath steering primitive for control and status paths. The combinational path is the primary output. The registered copy is for consumers that need a flop-clean source.

## Interface
Parameters:
- `NUM_IN`, default 4: number of selectable inputs. Legal range 2..4.
- `DATA_W`, default 1: width of each input lane, in bits.
- `SEL_W`, derived as `$clog2(NUM_IN)`, default 2: select width. Not overridable.

Ports:
- `clk`  in  1  sole clock. Clocks only `out_q`.
- `rst_n`  in  1  reset, asynchronous and active-low. Affects only `out_q`.
- `sel`  in  SEL_W  lane index; 0 selects `data_in[DATA_W-1:0]`.
- `data_in`  in  NUM_IN*DATA_W  packed input lanes; lane i is `data_in[i*DATA_W +: DATA_W]`.
- `out`  out  DATA_W  combinational selected lane.
- `out_q`  out  DATA_W  `out` registered on the rising edge of `clk`.
- `sel_err`  out  1  combinational. High when `sel >= NUM_IN`; never high at the default `NUM_IN` = 4.

## Operation
- `out = data_in[sel*DATA_W +: DATA_W]` for every `sel < NUM_IN`.
- With the default parameters: sel 00 gives `data_in[0]`, 01 gives `data_in[1]`, 10 gives `data_in[2]`, 11 gives `data_in[3]`.
- Out-of-range select (`sel >= NUM_IN`, possible only when `NUM_IN` = 3): `out` = 0 and `sel_err` = 1.
- `out` has no state. It does not depend on `clk` or `rst_n`, and it responds to changes on `sel` and `data_in` with equal priority.
- `out_q` captures `out` on each rising edge of `clk` while `rst_n` = 1.
- The block has no enable, no handshake and no state machine.
- X/Z on `sel` is outside the contract; output values in that case are unspecified.

## Timing
- `out` and `sel_err`: zero-cycle latency, purely combinational. The only delay is propagation delay. There is no path from `sel`/`data_in` through any flop to `out`.
- `out_q`: one-cycle latency. The value on `out` just before rising edge N appears on `out_q` after edge N.
- Reset: on `rst_n` falling, `out_q` goes to 0 immediately, with no clock required. `out_q` holds 0 while `rst_n` = 0.
- Reset release: the first capture happens on the first rising edge of `clk` after `rst_n` rises.
- Reset asserted mid-operation clears `out_q` only. `out` and `sel_err` keep tracking their inputs throughout reset.
- If `sel` and `data_in` change together, `out` settles to the new lane of the new data. There are no glitch-free guarantees.

## Structure
- Shared package `mux_pkg`:
  - holds default constants `MUX_NUM_IN` = 4 and `MUX_DATA_W` = 1;
  - holds function `mux_sel_w(n)` returning the clog2 select width.
- One sub-module is natural: `mux_sel_decode`. It converts `sel` into a one-hot lane enable of `NUM_IN` bits plus `sel_err`.
- The top level then forms `out` as an AND-OR reduction over the lanes and adds the single `out_q` register with async active-low clear.
- Elaboration-time assertions: `NUM_IN` in 2..4 and `DATA_W` >= 1.

## Test plan
- Default parameters, `data_in` = 4'b1010, sel stepped 00, 01, 10, 11 at 10 ns intervals: `out` = 0, 1, 0, 1 and `sel_err` = 0 throughout.
- Default parameters, `data_in` = 4'b0101, same sel sweep: `out` = 1, 0, 1, 0.
- Hold sel = 2'b10 and toggle `data_in` 4'b0000 to 4'b0100 to 4'b0000 with no clock edge: `out` follows 0, 1, 0 immediately.
- Registered path, `clk` at 10 ns period, reset released, `data_in` = 4'b1010, sel changed 00 to 01 between edges: `out_q` = 0 after the next edge, then 1 one edge after the change.
- Reset mid-run: `out_q` = 1, then `rst_n` driven low between edges. `out_q` goes to 0 immediately, `out` still equals the selected bit, and `out_q` resumes one edge after `rst_n` rises.
- `NUM_IN` = 3, `DATA_W` = 4, `data_in` = 12'hCBA: sel 0, 1, 2, 3 gives `out` = A, B, C, 0 and `sel_err` = 0, 0, 0, 1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the lane-select multiplexer family.
//   MUX_NUM_IN : default number of selectable lanes
//   MUX_DATA_W : default lane width in bits
//   mux_sel_w  : select width needed to address n lanes
package mux_pkg;

  localparam int unsigned MUX_NUM_IN = 4;
  localparam int unsigned MUX_DATA_W = 1;

  function automatic int unsigned mux_sel_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_sel_decode.sv
// Converts a binary lane index into a one-hot lane enable.
//   sel     : lane index
//   lane_en : one-hot enable, all zero when sel is out of range
//   sel_err : high when sel >= NUM_IN
module mux_sel_decode
  import mux_pkg::*;
#(
  parameter int unsigned NUM_IN = MUX_NUM_IN,
  parameter int unsigned SEL_W  = mux_sel_w(MUX_NUM_IN)
) (
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_IN-1:0] lane_en,
  output logic              sel_err
);

  always_comb begin
    lane_en = '0;
    sel_err = 1'b0;
    // Extra top bit so NUM_IN itself is representable in the compare.
    if ({1'b0, sel} >= (SEL_W + 1)'(NUM_IN)) begin
      sel_err = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        lane_en[i] = (sel == SEL_W'(i));
      end
    end
  end

endmodule

// File: rtl/mux_4to1_sv.sv
// Lane-select multiplexer with combinational and registered outputs.
//   clk     : clock, used only by out_q
//   rst_n   : async active-low clear of out_q
//   sel     : lane index, 0 selects data_in[DATA_W-1:0]
//   data_in : packed lanes, lane i at data_in[i*DATA_W +: DATA_W]
//   out     : selected lane, combinational (0 when sel out of range)
//   out_q   : out registered on rising clk
//   sel_err : high when sel >= NUM_IN
module mux_4to1_sv
  import mux_pkg::*;
#(
  parameter  int unsigned NUM_IN = MUX_NUM_IN,
  parameter  int unsigned DATA_W = MUX_DATA_W,
  localparam int unsigned SEL_W  = mux_sel_w(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]        out,
  output logic [DATA_W-1:0]        out_q,
  output logic                     sel_err
);

  if (NUM_IN < 2 || NUM_IN > 4) begin : g_bad_num_in
    $error("mux_4to1_sv: NUM_IN must be in 2..4");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("mux_4to1_sv: DATA_W must be at least 1");
  end

  logic [NUM_IN-1:0] lane_en;

  mux_sel_decode #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_decode (
    .sel     (sel),
    .lane_en (lane_en),
    .sel_err (sel_err)
  );

  // AND-OR reduction; an all-zero lane_en yields out = 0.
  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      out = out | (data_in[i*DATA_W +: DATA_W] & {DATA_W{lane_en[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux_4to1_sv.sv
module tb_mux_4to1_sv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = '0;
  logic [3:0]  d4 = '0;
  logic [11:0] d3 = '0;
  logic        out4, out4_q, err4;
  logic [3:0]  out3, out3_q;
  logic        err3;

  always #5 clk = ~clk;

  mux_4to1_sv u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .data_in (d4),
    .out     (out4),
    .out_q   (out4_q),
    .sel_err (err4)
  );

  mux_4to1_sv #(
    .NUM_IN (3),
    .DATA_W (4)
  ) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .data_in (d3),
    .out     (out3),
    .out_q   (out3_q),
    .sel_err (err3)
  );

  typedef struct {
    string      tag;
    logic       o4, q4, e4;
    logic [3:0] o3, q3;
    logic       e3;
  } exp_t;

  exp_t exp_q[$];
  event drv_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic       prev4 = 1'b0, m_q4 = 1'b0;
  logic [3:0] prev3 = '0,   m_q3 = '0;

  function automatic void chk(input string name, input string tag,
                              input logic [3:0] act, input logic [3:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s [%s]: got %h expected %h", name, tag, act, expv);
    end
  endfunction

  // after_edge: wait for the next rising edge first; otherwise advance 2 ns
  // without crossing an edge (callers keep at most 3 such steps in a row).
  task automatic step(input string tag, input logic [1:0] s, input logic [3:0] a,
                      input logic [11:0] b, input logic r, input bit after_edge);
    exp_t e;
    if (after_edge) begin
      @(posedge clk);
      #1;
      m_q4 = rst_n ? prev4 : 1'b0;
      m_q3 = rst_n ? prev3 : 4'h0;
    end else begin
      #2;
    end
    if (!r) begin
      m_q4 = 1'b0;
      m_q3 = '0;
    end
    sel = s; d4 = a; d3 = b; rst_n = r;
    prev4 = a[s];
    prev3 = (s < 2'd3) ? 4'((b >> (4 * s)) & 12'hF) : 4'h0;
    e.tag = tag;
    e.o4 = prev4; e.e4 = 1'b0; e.q4 = m_q4;
    e.o3 = prev3; e.e3 = (s == 2'd3); e.q3 = m_q3;
    exp_q.push_back(e);
    -> drv_ev;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(drv_ev);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: got output with no expectation queued, expected an entry");
      end else begin
        e = exp_q.pop_front();
        chk("out4",    e.tag, {3'b0, out4},   {3'b0, e.o4});
        chk("sel_err4",e.tag, {3'b0, err4},   {3'b0, e.e4});
        chk("out_q4",  e.tag, {3'b0, out4_q}, {3'b0, e.q4});
        chk("out3",    e.tag, out3,           e.o3);
        chk("sel_err3",e.tag, {3'b0, err3},   {3'b0, e.e3});
        chk("out_q3",  e.tag, out3_q,         e.q3);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned run;
    // Reset state, combinational paths live during reset
    step("rst",  2'd0, 4'b1010, 12'hCBA, 1'b0, 1'b1);
    step("rst",  2'd1, 4'b1010, 12'hCBA, 1'b0, 1'b1);
    // Sel sweeps, reset released
    for (int s = 0; s < 4; s++) step("sw1010", 2'(s), 4'b1010, 12'hCBA, 1'b1, 1'b1);
    for (int s = 0; s < 4; s++) step("sw0101", 2'(s), 4'b0101, 12'h5F3, 1'b1, 1'b1);
    // Data toggles with sel held, no edge between
    step("tog", 2'd2, 4'b0000, 12'h000, 1'b1, 1'b1);
    step("tog", 2'd2, 4'b0100, 12'hC00, 1'b1, 1'b0);
    step("tog", 2'd2, 4'b0000, 12'h000, 1'b1, 1'b0);
    // Registered path: sel 00 -> 01 between edges
    step("reg", 2'd0, 4'b1010, 12'hCBA, 1'b1, 1'b1);
    step("reg", 2'd1, 4'b1010, 12'hCBA, 1'b1, 1'b1);
    step("reg", 2'd1, 4'b1010, 12'hCBA, 1'b1, 1'b1);
    // Reset mid-run: out_q is 1, then async clear between edges
    step("mrst", 2'd1, 4'b1010, 12'hCBA, 1'b1, 1'b0);
    step("mrst", 2'd1, 4'b1010, 12'hCBA, 1'b0, 1'b0);
    step("mrst", 2'd3, 4'b1010, 12'hCBA, 1'b0, 1'b1);
    step("mrst", 2'd1, 4'b1010, 12'hCBA, 1'b1, 1'b1);
    step("mrst", 2'd1, 4'b1010, 12'hCBA, 1'b1, 1'b1);
    // Randomized traffic with occasional async reset and intra-cycle changes
    run = 0;
    for (int i = 0; i < 300; i++) begin
      bit ed;
      ed = (run >= 3) || ($urandom_range(0, 2) != 0);
      run = ed ? 0 : run + 1;
      step("rand", 2'($urandom), 4'($urandom), 12'($urandom),
           ($urandom_range(0, 19) != 0), ed);
    end
    #5;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
